// File: rtl/spi_slave_crc_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_crc_pkg
// Shared constants, FSM state type and the single long-division step used by
// the CRC-protected SPI receiver (spi_slave_crc_rx).
//
// Frame layout: 8 data bits followed by a 4-bit CRC (x^4+x+1), sent LSB first.
// After deserialization the frame word is {data[7:0], crc[3:0]}.
//
// Optional feature macro used by files importing this package:
//   SPI_RX_ERR_CNT_EN  adds the saturating err_cnt output.
// -----------------------------------------------------------------------------
package spi_crc_pkg;

  localparam logic [4:0] CRC_POLY   = 5'b10011;
  localparam int         FRAME_BITS = 12;
  localparam int         DATA_BITS  = 8;
  localparam int         CRC_BITS   = 4;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    SHIFT,
    CHECK,
    REPORT
  } rx_state_t;

  // One step of polynomial long division over the whole frame word. When the
  // bit at position idx is set, the 5-bit polynomial is XORed in with its MSB
  // aligned to idx, which clears that bit. Running idx from 11 down to 4
  // leaves the remainder in bits [3:0].
  function automatic logic [FRAME_BITS-1:0] crc_step(
    input logic [FRAME_BITS-1:0] work,
    input logic [3:0]            idx
  );
    logic [FRAME_BITS-1:0] mask;
    mask = {{(FRAME_BITS-CRC_BITS-1){1'b0}}, CRC_POLY} << (idx - 4'(CRC_BITS));
    return work[idx] ? (work ^ mask) : work;
  endfunction

endpackage

// File: rtl/spi_slave_crc_rx_if.sv
// -----------------------------------------------------------------------------
// spi_slave_crc_rx_if
// Bundles the SPI pins and the result/status signals of the CRC receiver.
//
// Signals:
//   sclk, cs, mosi   SPI pins (cs active low), driven by the SPI master side
//   dout[7:0]        received data byte
//   crc_rx[3:0]      received CRC field
//   valid            one-cycle pulse per checked frame
//   crc_ok           remainder was zero (qualified by valid)
//   crc_err          one-cycle pulse with valid when remainder nonzero
//   frame_err        one-cycle pulse on a bad bit count at cs rise
//   busy             receiver is not idle
//   err_cnt[7:0]     saturating error count (only with SPI_RX_ERR_CNT_EN)
//
// Modports:
//   slave   the receiver (spi_slave_crc_rx)
//   master  the side driving the pins and consuming the results
// -----------------------------------------------------------------------------
interface spi_slave_crc_rx_if;
  import spi_crc_pkg::*;

  logic                 sclk;
  logic                 cs;
  logic                 mosi;
  logic [DATA_BITS-1:0] dout;
  logic [CRC_BITS-1:0]  crc_rx;
  logic                 valid;
  logic                 crc_ok;
  logic                 crc_err;
  logic                 frame_err;
  logic                 busy;
`ifdef SPI_RX_ERR_CNT_EN
  logic [7:0]           err_cnt;
`endif

  modport slave (
    input  sclk, cs, mosi,
    output dout, crc_rx, valid, crc_ok, crc_err, frame_err,
`ifdef SPI_RX_ERR_CNT_EN
    output err_cnt,
`endif
    output busy
  );

  modport master (
    output sclk, cs, mosi,
    input  dout, crc_rx, valid, crc_ok, crc_err, frame_err,
`ifdef SPI_RX_ERR_CNT_EN
    input  err_cnt,
`endif
    input  busy
  );

endinterface

// File: rtl/spi_slave_crc_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous pin into the clk domain through SYNC_STAGES flops
// and flags its rising and falling edges using one extra history flop.
//
// Parameters:
//   SYNC_STAGES  number of synchronizer flops (2 or 3)
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   din   asynchronous input pin
//   sync  synchronized level (last synchronizer stage)
//   rise  high for one clk when sync goes 0 -> 1
//   fall  high for one clk when sync goes 1 -> 0
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   prev;

  // Synchronizer chain plus history flop. Clearing to 0 means a pin that is
  // high at reset release only ever produces a rise, never a spurious fall,
  // so a cs held low through reset cannot start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
      prev   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      prev   <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_crc_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_crc_rx
// SPI slave receiver for a 12-bit frame (8 data + 4-bit CRC, x^4+x+1, LSB
// first on mosi while cs is low). sclk, cs and mosi are oversampled in the clk
// domain; mosi is taken on each detected sclk falling edge, except the first
// one after cs falls, which is a dead edge. After cs rises with exactly 12
// bits the frame is divided by the polynomial one bit per clk (8 cycles) and
// the result is reported with a one-cycle valid pulse.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on sclk/cs/mosi (2 or 3); each sclk
//                half-period must be at least SYNC_STAGES+2 clk
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   spi_slave_crc_rx_if.slave (pins in; dout, crc_rx, valid, crc_ok,
//         crc_err, frame_err, busy, optional err_cnt out)
//
// Optional feature: define SPI_RX_ERR_CNT_EN to add err_cnt, a saturating
// count of crc_err and frame_err pulses cleared only by rst.
// -----------------------------------------------------------------------------
module spi_slave_crc_rx
  import spi_crc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_slave_crc_rx_if.slave     bus
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_edges;

  rx_state_t state_q, state_d;

  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] work;
  logic [3:0]            bit_cnt;
  logic [2:0]            step_cnt;
  logic [3:0]            step_idx;

  logic clr_frame, shift_en, load_work, check_en, report, frame_err_set;

  logic [DATA_BITS-1:0] dout_q;
  logic [CRC_BITS-1:0]  crc_rx_q;
  logic                 valid_q, crc_ok_q, crc_err_q, frame_err_q;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk (clk), .rst (rst), .din (bus.sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk (clk), .rst (rst), .din (bus.cs),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk (clk), .rst (rst), .din (bus.mosi),
    .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only sclk falls, cs edges and the mosi level drive the receiver.
  assign unused_edges = ^{sclk_sync, sclk_rise, cs_sync, mosi_rise, mosi_fall};

  // Division runs from the frame MSB (bit 11) down to bit 4.
  assign step_idx = 4'(FRAME_BITS - 1) - {1'b0, step_cnt};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A cs rise wins over a simultaneous sclk fall, and cs
  // edges in CHECK/REPORT are ignored because the master never starts a new
  // frame that soon.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SKIP;
      SKIP: begin
        if (cs_rise)        state_d = IDLE;
        else if (sclk_fall) state_d = SHIFT;
      end
      SHIFT: begin
        if (cs_rise) state_d = (bit_cnt == 4'(FRAME_BITS)) ? CHECK : IDLE;
      end
      CHECK:   if (step_cnt == 3'(DATA_BITS - 1)) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: datapath strobes and busy, all from the current state.
  always_comb begin
    clr_frame     = (state_q == IDLE) && cs_fall;
    shift_en      = (state_q == SHIFT) && sclk_fall && !cs_rise;
    load_work     = (state_q == SHIFT) && cs_rise && (bit_cnt == 4'(FRAME_BITS));
    frame_err_set = ((state_q == SHIFT) && cs_rise && (bit_cnt != 4'(FRAME_BITS)))
                  || ((state_q == SKIP) && cs_rise);
    check_en      = (state_q == CHECK);
    report        = (state_q == REPORT);
    bus.busy      = (state_q != IDLE);
  end

  // Deserializer. bit_cnt sticks at 13 so any overrun still reads as a bad
  // length when cs rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr_frame) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr <= {mosi_s, sr[FRAME_BITS-1:1]};
      if (bit_cnt != 4'(FRAME_BITS + 1)) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Serial CRC check: snapshot the frame, then one division step per clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      step_cnt <= '0;
    end else if (load_work) begin
      work     <= sr;
      step_cnt <= '0;
    end else if (check_en) begin
      work     <= crc_step(work, step_idx);
      step_cnt <= step_cnt + 3'd1;
    end
  end

  // Result registers. dout/crc_rx/crc_ok hold between frames; the three
  // status strobes are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      crc_rx_q    <= '0;
      crc_ok_q    <= 1'b0;
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= frame_err_set;
      if (report) begin
        dout_q    <= sr[FRAME_BITS-1:CRC_BITS];
        crc_rx_q  <= sr[CRC_BITS-1:0];
        valid_q   <= 1'b1;
        crc_ok_q  <= (work[CRC_BITS-1:0] == '0);
        crc_err_q <= (work[CRC_BITS-1:0] != '0);
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.crc_rx    = crc_rx_q;
  assign bus.valid     = valid_q;
  assign bus.crc_ok    = crc_ok_q;
  assign bus.crc_err   = crc_err_q;
  assign bus.frame_err = frame_err_q;

`ifdef SPI_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of every error pulse; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if ((crc_err_q || frame_err_q) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave_crc_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_crc_rx
// Drives SPI frames into spi_slave_crc_rx and checks each valid / frame_err
// pulse against an expected-result queue filled as frames are sent.
// Honours SPI_RX_ERR_CNT_EN for the optional error counter.
// -----------------------------------------------------------------------------
module tb_spi_slave_crc_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;
  localparam int GAP         = 16;
  localparam int VALID_LAT   = SYNC_STAGES + 1 + 9;

  typedef struct {
    logic       fe;
    logic [7:0] data;
    logic [3:0] crc;
    logic       ok;
  } exp_t;

  typedef struct {
    logic [12:0] word;
    int          nbits;
    logic        exp_fe;
    logic        exp_ok;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int   checks    = 0;
  int   errors    = 0;
  int   pulses    = 0;
  int   exp_errs  = 0;
  logic prev_pulse = 1'b0;
  logic pulse_now;
  exp_t mon_e;
  exp_t sb[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  spi_slave_crc_rx_if bus();

  spi_slave_crc_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit-serial CRC generator, MSB first, used to build good check fields.
  function automatic logic [3:0] crcModel(input logic [7:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      fb = d[i] ^ c[3];
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ 4'h3;
    end
    return c;
  endfunction

  task automatic checkErrCnt();
`ifdef SPI_RX_ERR_CNT_EN
    checkOutput("err_cnt", 32'(bus.err_cnt), (exp_errs > 255) ? 32'd255 : 32'(exp_errs));
`endif
  endtask

  // Sends cs low, one dead sclk edge, then nbits of word LSB first, raises cs
  // and waits for the result pulse, leaving GAP clk between frames.
  task automatic applyStimulus(input logic [12:0] word, input int nbits,
                               input logic exp_fe, input logic exp_ok);
    exp_t e;
    int   lat;
    e.fe = exp_fe;
    e.data = word[11:4];
    e.crc = word[3:0];
    e.ok = exp_ok;
    sb.push_back(e);
    if (exp_fe || !exp_ok) exp_errs++;
    bus.cs = 1'b0;
    waitClk(HALF);
    bus.sclk = 1'b1;
    waitClk(HALF);
    bus.sclk = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < nbits; i++) begin
      bus.sclk = 1'b1;
      bus.mosi = word[i];
      waitClk(HALF);
      bus.sclk = 1'b0;
      waitClk(HALF);
    end
    checkOutput("busy_in_frame", 32'(bus.busy), 32'd1);
    bus.cs = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      waitClk(1);
      if (bus.valid || bus.frame_err) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL pulse_timeout: got no valid/frame_err within 40 clk");
    end else if (!exp_fe) begin
      checkOutput("valid_latency", 32'(lat), 32'(VALID_LAT));
    end
    if (lat < GAP) waitClk(GAP - lat);
    checkOutput("busy_after_frame", 32'(bus.busy), 32'd0);
    checkErrCnt();
  endtask

  // cs toggled with no sclk activity: abort from SKIP.
  task automatic abortFrame();
    exp_t e;
    e.fe = 1'b1;
    e.data = 8'h00;
    e.crc = 4'h0;
    e.ok = 1'b0;
    sb.push_back(e);
    exp_errs++;
    bus.cs = 1'b0;
    waitClk(HALF);
    bus.cs = 1'b1;
    waitClk(GAP);
  endtask

  // Scoreboard consumer: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    pulse_now = bus.valid | bus.frame_err | bus.crc_err;
    if (!rst && pulse_now) begin
      pulses++;
      checkOutput("pulse_width", 32'(prev_pulse), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got valid=%b frame_err=%b crc_err=%b, want none",
                 bus.valid, bus.frame_err, bus.crc_err);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_kind", {30'd0, bus.valid, bus.frame_err},
                    mon_e.fe ? 32'd1 : 32'd2);
        if (!mon_e.fe) begin
          checkOutput("dout", 32'(bus.dout), 32'(mon_e.data));
          checkOutput("crc_rx", 32'(bus.crc_rx), 32'(mon_e.crc));
          checkOutput("crc_ok", 32'(bus.crc_ok), 32'(mon_e.ok));
          checkOutput("crc_err", 32'(bus.crc_err), 32'(!mon_e.ok));
        end
      end
    end
    prev_pulse = pulse_now;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int            p0;
    logic [7:0]    d;
    logic [3:0]    c;
    logic [12:0]   w;

    // 0xA5 checks to 0xB under x^4+x+1; 0xA5E is therefore a bad frame.
    vecs[0] = '{13'h0A5B, 12, 1'b0, 1'b1};
    vecs[1] = '{13'h0A5E, 12, 1'b0, 1'b0};
    vecs[2] = '{13'h0A1B, 12, 1'b0, 1'b0};
    vecs[3] = '{13'h0013, 12, 1'b0, 1'b1};
    vecs[4] = '{13'h0000, 12, 1'b0, 1'b1};
    vecs[5] = '{13'h0A5B,  7, 1'b1, 1'b0};
    vecs[6] = '{13'h1A5B, 13, 1'b1, 1'b0};
    vecs[7] = '{13'h0A5B, 12, 1'b0, 1'b1};
    vecs[8] = '{13'h0FF4, 12, 1'b0, 1'b1};

    rst      = 1'b1;
    bus.cs   = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(bus.valid), 32'd0);
    checkOutput("rst_frame_err", 32'(bus.frame_err), 32'd0);
    checkOutput("rst_crc_err", 32'(bus.crc_err), 32'd0);
    checkOutput("rst_crc_ok", 32'(bus.crc_ok), 32'd0);
    checkOutput("rst_dout", 32'(bus.dout), 32'd0);
    checkOutput("rst_crc_rx", 32'(bus.crc_rx), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkErrCnt();
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitClk(8);

    $display("[TB] cs toggle without sclk");
    abortFrame();
    checkErrCnt();

    $display("[TB] vector table");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k].word, vecs[k].nbits, vecs[k].exp_fe, vecs[k].exp_ok);
    end

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom_range(0, 255));
      c = crcModel(d);
      applyStimulus({1'b0, d, c}, 12, 1'b0, 1'b1);
      c = c ^ 4'($urandom_range(1, 15));
      applyStimulus({1'b0, d, c}, 12, 1'b0, 1'b0);
    end

    $display("[TB] reset in mid-frame");
    p0 = pulses;
    w = 13'h0A5B;
    bus.cs = 1'b0;
    waitClk(HALF);
    bus.sclk = 1'b1;
    waitClk(HALF);
    bus.sclk = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        rst = 1'b1;
        waitClk(3);
        checkOutput("busy_in_reset", 32'(bus.busy), 32'd0);
        rst = 1'b0;
      end
      bus.sclk = 1'b1;
      bus.mosi = w[i];
      waitClk(HALF);
      bus.sclk = 1'b0;
      waitClk(HALF);
    end
    checkOutput("busy_after_reset", 32'(bus.busy), 32'd0);
    bus.cs = 1'b1;
    waitClk(GAP + 8);
    checkOutput("no_pulse_after_reset", 32'(pulses - p0), 32'd0);
`ifdef SPI_RX_ERR_CNT_EN
    exp_errs = 0;
`endif
    applyStimulus(13'h0A5B, 12, 1'b0, 1'b1);
    applyStimulus(13'h0013, 12, 1'b0, 1'b1);

`ifdef SPI_RX_ERR_CNT_EN
    $display("[TB] error counter saturation");
    for (int k = 0; k < 300; k++) begin
      abortFrame();
    end
    checkErrCnt();
`endif

    for (int n = 0; n < 200 && sb.size() != 0; n++) waitClk(1);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
